axil_simpleuart_bridge: RTL and testbench
=========================================

Name: axil_simpleuart_bridge

Overview:
- AXI4-Lite slave that converts single-beat bus transactions into the simpleuart register strobe interface (divider and data registers).
- Sits directly upstream of simpleuart inside top_uart_axi; its slave port faces the interconnect/CPU.
- Serializes reads and writes, stalls on UART transmit back-pressure, and returns OKAY/SLVERR responses.

Parameters:
- ADDR_WIDTH, 4, width of the s_axi_awaddr/s_axi_araddr local offsets; decode uses bits [3:2], all other bits are ignored.
- DATA_WIDTH, 32, bus data width; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake
- s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axi_bvalid / s_axi_bready  out/in  1  write-response handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake
- reg_div_we  out  4  divider byte write enables to simpleuart
- reg_div_di  out  32  divider write data
- reg_div_do  in  32  current divider value
- reg_dat_we  out  1  transmit-byte request
- reg_dat_re  out  1  receive-byte consume pulse
- reg_dat_di  out  32  transmit data, byte in [7:0]
- reg_dat_do  in  32  received byte, or 32'hFFFFFFFF when empty
- reg_dat_wait  in  1  simpleuart busy; holds reg_dat_we pending

Behaviour:
- Register map, by offset:
  - 0x0 DIV: RW.
  - 0x4 DAT: write transmits wdata[7:0]; read returns reg_dat_do and consumes the byte.
  - 0x8 and above: SLVERR, no side effect (0x8 is handled differently when the optional feature is compiled in).
- Reset: all ready/valid outputs, reg_* strobes, bresp/rresp, rdata and reg_div_di/reg_dat_di are 0; FSM is IDLE.
- AW and W are accepted independently, in any order or in the same cycle. Each is latched, and its ready deasserts until the write completes. One outstanding write and one outstanding read at most.
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP.
  - IDLE -> WR_EXEC when both AW and W are latched.
  - IDLE -> RD_EXEC when AR is latched.
  - If both become eligible in the same cycle, grant the direction not granted last. After reset, write wins first.
- WR_EXEC:
  - DIV: reg_div_we = wstrb for exactly 1 cycle, reg_div_di = wdata; go to WR_RESP with OKAY.
  - DAT with wstrb[0]=1: hold reg_dat_we=1 and reg_dat_di={24'b0,wdata[7:0]} until a cycle with reg_dat_wait=0; deassert next cycle; go to WR_RESP.
  - DAT with wstrb[0]=0: no strobe, OKAY.
  - Unmapped address: no strobe, SLVERR.
- WR_RESP: bvalid held until bready. Then clear the AW/W latches, reassert awready/wready, return to IDLE.
- RD_EXEC (1 cycle): rdata captured.
  - DIV: reg_div_do.
  - DAT: reg_dat_do, with reg_dat_re=1 for that single cycle. reg_dat_re is pulsed even when the buffer is empty.
  - Unmapped: 0 with SLVERR.
- RD_RESP: rvalid held, rdata stable, until rready.
- Latency:
  - DIV write: AW+W latched to bvalid = 2 cycles.
  - DAT write: 2 cycles plus the number of wait cycles.
  - Read: AR latched to rvalid = 2 cycles.
- Each strobe fires exactly once per transaction; response back-pressure never repeats a strobe.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight transaction is dropped with no response.

Optional Feature:
- Macro: AXIL_UART_COUNTERS_EN.
- With the macro:
  - Offset 0x8 CNT read returns {rx_count[15:0], tx_count[15:0]} with OKAY.
  - Any write to 0x8 clears both counters, OKAY.
  - tx_count increments on each completed DAT transmit.
  - rx_count increments on each DAT read where reg_dat_do != 32'hFFFFFFFF.
  - Both counters wrap 16'hFFFF -> 0 and reset to 0.
- Without the macro: offset 0x8 returns SLVERR and no counter logic exists.

Test Plan:
- Write DIV 0x0 = 0x00000068, wstrb 4'hF, AW two cycles before W -> reg_div_we=4'hF for 1 cycle, reg_div_di=0x68, bresp=00; subsequent read of 0x0 returns 0x68.
- Write DAT 0x4 = 0x41 with reg_dat_wait held high 5 cycles -> reg_dat_we high 6 cycles, bvalid 7 cycles after latch, exactly one byte sent.
- Read DAT with reg_dat_do=0x0000005A -> rdata=0x5A, rresp=00, reg_dat_re single-cycle pulse; with reg_dat_do=0xFFFFFFFF -> rdata=0xFFFFFFFF.
- AW/W and AR presented the same cycle after reset, bready/rready held low 3 cycles -> write executes first, read second, no duplicate strobes, both responses delivered.
- Read/write to 0xC -> SLVERR, rdata=0, no reg_* strobe; 0x8 is SLVERR without the macro.
- With AXIL_UART_COUNTERS_EN: 3 DAT writes, 2 non-empty DAT reads, then read 0x8 -> 0x00020003; write 0x8 then read -> 0x00000000.

Source files
------------

// File: rtl/axil_simpleuart_bridge.sv
// axil_simpleuart_bridge
//   AXI4-Lite slave that turns single-beat reads/writes into the simpleuart
//   register strobe interface (DIV at offset 0x0, DAT at offset 0x4).
//   Reads and writes are serialized. A DAT write stalls while the UART reports
//   reg_dat_wait. Unmapped offsets return SLVERR and cause no side effect.
//
// Ports
//   clk, resetn              : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*          : AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*             : AXI4-Lite read address/data channels
//   reg_div_we/di/do         : divider byte enables, write data, current value
//   reg_dat_we/re/di/do/wait : transmit request, receive consume, tx byte,
//                              rx byte (all ones when empty), tx busy
//
// Optional feature (macro AXIL_UART_COUNTERS_EN)
//   Offset 0x8 becomes CNT. A read returns {rx_count, tx_count}. Any write
//   clears both counters. Without the macro, offset 0x8 answers SLVERR.
module axil_simpleuart_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [3:0]              reg_div_we,
  output logic [31:0]             reg_div_di,
  input  logic [31:0]             reg_div_do,
  output logic                    reg_dat_we,
  output logic                    reg_dat_re,
  output logic [31:0]             reg_dat_di,
  input  logic [31:0]             reg_dat_do,
  input  logic                    reg_dat_wait
);

  typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP} state_t;

  localparam logic [1:0] SEL_DIV     = 2'd0;
  localparam logic [1:0] SEL_DAT     = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_UART_COUNTERS_EN
  localparam logic [1:0] SEL_CNT     = 2'd2;
  logic [15:0] tx_count_reg, rx_count_reg;
`endif

  state_t state_reg, state_next;

  logic                  aw_latched_reg, w_latched_reg, ar_latched_reg;
  logic                  awready_reg, wready_reg, arready_reg;
  logic [1:0]            aw_sel_reg, ar_sel_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  last_wr_reg;   // 1 when the last grant went to a write
  logic [1:0]            bresp_reg, bresp_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

  logic aw_hs, w_hs, ar_hs;
  logic wr_done, rd_done, grant_wr, grant_rd;

  // Decode looks only at address bits [3:2]; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_hs = s_axi_awvalid & awready_reg;
  assign w_hs  = s_axi_wvalid  & wready_reg;
  assign ar_hs = s_axi_arvalid & arready_reg;

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_arready = arready_reg;
  assign s_axi_bvalid  = (state_reg == WR_RESP);
  assign s_axi_rvalid  = (state_reg == RD_RESP);
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_rresp   = rresp_reg;
  assign s_axi_rdata   = rdata_reg;

  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    bresp_next = bresp_reg;
    rresp_next = rresp_reg;
    rdata_next = rdata_reg;
    reg_div_we = 4'h0;
    reg_div_di = 32'h0;
    reg_dat_we = 1'b0;
    reg_dat_di = 32'h0;
    reg_dat_re = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie, favour the direction that did not win last time.
        if (aw_latched_reg && w_latched_reg && (!ar_latched_reg || !last_wr_reg)) begin
          grant_wr   = 1'b1;
          state_next = WR_EXEC;
        end else if (ar_latched_reg) begin
          grant_rd   = 1'b1;
          state_next = RD_EXEC;
        end
      end
      WR_EXEC: begin
        state_next = WR_RESP;
        bresp_next = RESP_OKAY;
        case (aw_sel_reg)
          SEL_DIV: begin
            reg_div_we = wstrb_reg;
            reg_div_di = wdata_reg;
          end
          SEL_DAT: begin
            if (wstrb_reg[0]) begin
              reg_dat_we = 1'b1;
              reg_dat_di = {24'h0, wdata_reg[7:0]};
              // Stay here with the request held until the UART accepts it.
              if (reg_dat_wait) state_next = WR_EXEC;
            end
          end
`ifdef AXIL_UART_COUNTERS_EN
          SEL_CNT: ;
`endif
          default: bresp_next = RESP_SLVERR;
        endcase
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          wr_done    = 1'b1;
          state_next = IDLE;
        end
      end
      RD_EXEC: begin
        state_next = RD_RESP;
        rresp_next = RESP_OKAY;
        case (ar_sel_reg)
          SEL_DIV: rdata_next = reg_div_do;
          SEL_DAT: begin
            rdata_next = reg_dat_do;
            reg_dat_re = 1'b1;
          end
`ifdef AXIL_UART_COUNTERS_EN
          SEL_CNT: rdata_next = {rx_count_reg, tx_count_reg};
`endif
          default: begin
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
          end
        endcase
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      ar_latched_reg <= 1'b0;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      arready_reg    <= 1'b0;
      aw_sel_reg     <= 2'd0;
      ar_sel_reg     <= 2'd0;
      wdata_reg      <= '0;
      wstrb_reg      <= 4'h0;
      last_wr_reg    <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      rresp_reg      <= RESP_OKAY;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      bresp_reg <= bresp_next;
      rresp_reg <= rresp_next;
      rdata_reg <= rdata_next;

      if (aw_hs) begin
        aw_latched_reg <= 1'b1;
        aw_sel_reg     <= s_axi_awaddr[3:2];
      end else if (wr_done) begin
        aw_latched_reg <= 1'b0;
      end
      if (w_hs) begin
        w_latched_reg <= 1'b1;
        wdata_reg     <= s_axi_wdata;
        wstrb_reg     <= s_axi_wstrb;
      end else if (wr_done) begin
        w_latched_reg <= 1'b0;
      end
      if (ar_hs) begin
        ar_latched_reg <= 1'b1;
        ar_sel_reg     <= s_axi_araddr[3:2];
      end else if (rd_done) begin
        ar_latched_reg <= 1'b0;
      end

      // Ready drops on the accepting edge and returns when the slot frees.
      awready_reg <= wr_done | (~aw_latched_reg & ~aw_hs);
      wready_reg  <= wr_done | (~w_latched_reg & ~w_hs);
      arready_reg <= rd_done | (~ar_latched_reg & ~ar_hs);

      if (grant_wr)      last_wr_reg <= 1'b1;
      else if (grant_rd) last_wr_reg <= 1'b0;
    end
  end

`ifdef AXIL_UART_COUNTERS_EN
  logic tx_inc, rx_inc, cnt_clr;
  assign tx_inc  = (state_reg == WR_EXEC) && (aw_sel_reg == SEL_DAT) && wstrb_reg[0] && !reg_dat_wait;
  assign rx_inc  = (state_reg == RD_EXEC) && (ar_sel_reg == SEL_DAT) && (reg_dat_do != 32'hFFFF_FFFF);
  assign cnt_clr = (state_reg == WR_EXEC) && (aw_sel_reg == SEL_CNT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_count_reg <= 16'h0;
      rx_count_reg <= 16'h0;
    end else if (cnt_clr) begin
      tx_count_reg <= 16'h0;
      rx_count_reg <= 16'h0;
    end else begin
      if (tx_inc) tx_count_reg <= tx_count_reg + 16'h1;
      if (rx_inc) rx_count_reg <= rx_count_reg + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_simpleuart_bridge.sv
module tb_axil_simpleuart_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
  logic        reg_dat_wait = 1'b0;

  axil_simpleuart_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the simpleuart divider register.
  logic [31:0] div_model = 32'h0;
  assign reg_div_do = div_model;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (reg_div_we[b]) div_model[8*b +: 8] <= reg_div_di[8*b +: 8];
  end

  typedef struct { logic [1:0] resp; logic [31:0] data; } resp_t;
  typedef struct { int kind; logic [3:0] we; logic [31:0] data; } strb_t; // kind 0 div, 1 tx, 2 re
  resp_t bq[$];
  resp_t rq[$];
  strb_t sq[$];

  int checks = 0;
  int failures = 0;
  int div_we_cycles = 0, dat_we_cycles = 0, tx_bytes = 0;
  int bvalid_rise_cyc = 0, rvalid_rise_cyc = 0, last_latch_cyc = 0;
  logic bvalid_prev = 1'b0, rvalid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [1:0] resp);
    resp_t e; e.resp = resp; e.data = 32'h0; bq.push_back(e);
  endtask
  task automatic push_r(input logic [1:0] resp, input logic [31:0] data);
    resp_t e; e.resp = resp; e.data = data; rq.push_back(e);
  endtask
  task automatic push_s(input int kind, input logic [3:0] we, input logic [31:0] data);
    strb_t e; e.kind = kind; e.we = we; e.data = data; sq.push_back(e);
  endtask

  task automatic pop_strobe(input string name, input int kind, input logic [3:0] we, input logic [31:0] data);
    strb_t e;
    if (sq.size() == 0) begin
      check({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sq.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_we"}, {28'h0, we}, {28'h0, e.we});
      check({name, "_data"}, data, e.data);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    resp_t e;
    if (resetn) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin e = bq.pop_front(); check("bresp", {30'h0, s_axi_bresp}, {30'h0, e.resp}); end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          e = rq.pop_front();
          check("rresp", {30'h0, s_axi_rresp}, {30'h0, e.resp});
          check("rdata", s_axi_rdata, e.data);
        end
      end
      if (s_axi_bvalid && !bvalid_prev) bvalid_rise_cyc = cyc;
      if (s_axi_rvalid && !rvalid_prev) rvalid_rise_cyc = cyc;
      if (reg_div_we != 4'h0) begin
        div_we_cycles++;
        pop_strobe("div_strobe", 0, reg_div_we, reg_div_di);
      end
      if (reg_dat_we) dat_we_cycles++;
      if (reg_dat_we && !reg_dat_wait) begin
        tx_bytes++;
        pop_strobe("tx_strobe", 1, 4'h0, reg_dat_di);
      end
      if (reg_dat_re) pop_strobe("re_strobe", 2, 4'h0, 32'h0);
    end
    bvalid_prev = s_axi_bvalid;
    rvalid_prev = s_axi_rvalid;
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lag);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = (w_lag == 0);
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_axi_wvalid = 1'b0; end
      n++;
      if (n >= w_lag && !w_done) s_axi_wvalid = 1'b1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    last_latch_cyc = cyc;
    if (!(aw_done && w_done)) check("aw_w_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a);
    bit hs = 0;
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    last_latch_cyc = cyc;
    if (!hs) check("ar_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bq.size() + rq.size() + sq.size()) != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_done"}, (n >= 200), 32'd0);
  endtask

  typedef struct {
    bit is_read; logic [3:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] dat_do; logic [1:0] resp; logic [31:0] rdata;
    int skind; logic [3:0] swe; logic [31:0] sdata;
  } vec_t;
  localparam int NV = 11;
  vec_t vec[NV];

  initial begin
    // kind -1 means the access must produce no strobe at all
    vec[0]  = '{1'b1, 4'h0, 32'h0,         4'h0, 32'h0,         2'b00, 32'h0000_0068, -1, 4'h0, 32'h0};
    vec[1]  = '{1'b0, 4'h0, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00, 32'h0,          0, 4'h5, 32'hAABB_CCDD};
    vec[2]  = '{1'b1, 4'h1, 32'h0,         4'h0, 32'h0,         2'b00, 32'h00BB_00DD, -1, 4'h0, 32'h0};
    vec[3]  = '{1'b0, 4'h4, 32'h1234_5641, 4'h1, 32'h0,         2'b00, 32'h0,          1, 4'h0, 32'h41};
    vec[4]  = '{1'b0, 4'h7, 32'h0000_00C3, 4'h1, 32'h0,         2'b00, 32'h0,          1, 4'h0, 32'hC3};
    vec[5]  = '{1'b0, 4'h4, 32'h0000_00FF, 4'hE, 32'h0,         2'b00, 32'h0,         -1, 4'h0, 32'h0};
    vec[6]  = '{1'b1, 4'h4, 32'h0,         4'h0, 32'h0000_005A, 2'b00, 32'h0000_005A,  2, 4'h0, 32'h0};
    vec[7]  = '{1'b1, 4'h4, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF,  2, 4'h0, 32'h0};
    vec[8]  = '{1'b0, 4'hC, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b10, 32'h0,         -1, 4'h0, 32'h0};
    vec[9]  = '{1'b1, 4'hC, 32'h0,         4'h0, 32'h0000_0077, 2'b10, 32'h0,         -1, 4'h0, 32'h0};
    vec[10] = '{1'b1, 4'hF, 32'h0,         4'h0, 32'h0000_0077, 2'b10, 32'h0,         -1, 4'h0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
    check("rst_valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    check("rst_strobes", {26'h0, reg_div_we, reg_dat_we, reg_dat_re}, 32'h0);
    check("rst_resp", {28'h0, s_axi_bresp, s_axi_rresp}, 32'h0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_div_di", reg_div_di, 32'h0);
    check("rst_dat_di", reg_dat_di, 32'h0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write and read offered together right after reset: write must go first.
    s_axi_bready = 1'b0; s_axi_rready = 1'b0; reg_dat_do = 32'h33;
    push_s(0, 4'h1, 32'h11); push_s(2, 4'h0, 32'h0);
    push_b(2'b00); push_r(2'b00, 32'h33);
    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h11; s_axi_wstrb = 4'h1; s_axi_araddr = 4'h4;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("tie_all_ready", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    last_latch_cyc = cyc;
    repeat (4) @(negedge clk);
    check("tie_b_first", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h2);
    check("tie_b_latency", bvalid_rise_cyc - last_latch_cyc, 32'd2);
    @(posedge clk); #1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    wait_idle("tie");

    // DIV write, W two cycles after AW
    push_s(0, 4'hF, 32'h68); push_b(2'b00);
    div_we_cycles = 0;
    axi_write(4'h0, 32'h68, 4'hF, 2);
    wait_idle("div_wr");
    check("div_we_cycles", div_we_cycles, 32'd1);
    check("div_b_latency", bvalid_rise_cyc - last_latch_cyc, 32'd2);

    // Table-driven single accesses
    for (int i = 0; i < NV; i++) begin
      reg_dat_do = vec[i].dat_do;
      if (vec[i].skind >= 0) push_s(vec[i].skind, vec[i].swe, vec[i].sdata);
      if (vec[i].is_read) begin
        push_r(vec[i].resp, vec[i].rdata);
        axi_read(vec[i].addr);
      end else begin
        push_b(vec[i].resp);
        axi_write(vec[i].addr, vec[i].wdata, vec[i].wstrb, 0);
      end
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_latency", i),
            (vec[i].is_read ? rvalid_rise_cyc : bvalid_rise_cyc) - last_latch_cyc, 32'd2);
    end

    // DAT write stalled by the UART for 5 cycles
    push_s(1, 4'h0, 32'h41); push_b(2'b00);
    reg_dat_wait = 1'b1; dat_we_cycles = 0; tx_bytes = 0;
    axi_write(4'h4, 32'h0000_0041, 4'h1, 0);
    repeat (6) @(posedge clk);
    #1 reg_dat_wait = 1'b0;
    wait_idle("dat_wait");
    check("dat_we_cycles", dat_we_cycles, 32'd6);
    check("dat_b_latency", bvalid_rise_cyc - last_latch_cyc, 32'd7);
    check("dat_tx_bytes", tx_bytes, 32'd1);

`ifdef AXIL_UART_COUNTERS_EN
    push_b(2'b00); axi_write(4'h8, 32'h0, 4'hF, 0); wait_idle("cnt_clr0");
    for (int k = 0; k < 3; k++) begin
      push_s(1, 4'h0, 32'h30 + k); push_b(2'b00);
      axi_write(4'h4, 32'h30 + k, 4'h1, 0); wait_idle("cnt_tx");
    end
    for (int k = 0; k < 3; k++) begin
      reg_dat_do = (k == 2) ? 32'hFFFF_FFFF : 32'h60 + k;
      push_s(2, 4'h0, 32'h0); push_r(2'b00, reg_dat_do);
      axi_read(4'h4); wait_idle("cnt_rx");
    end
    push_r(2'b00, 32'h0002_0003); axi_read(4'h8); wait_idle("cnt_rd");
    push_b(2'b00); axi_write(4'h8, 32'h0, 4'h1, 0); wait_idle("cnt_clr");
    push_r(2'b00, 32'h0); axi_read(4'h8); wait_idle("cnt_rd0");
`else
    push_b(2'b10); axi_write(4'h8, 32'h1234_5678, 4'hF, 0); wait_idle("off8_wr");
    push_r(2'b10, 32'h0); reg_dat_do = 32'h99; axi_read(4'h8); wait_idle("off8_rd");
`endif

    // Reset in the middle of a stalled DAT write: dropped, no response.
    reg_dat_wait = 1'b1; tx_bytes = 0;
    axi_write(4'h4, 32'h55, 4'h1, 0);
    @(posedge clk); #1;
    check("mid_we_before_rst", {31'h0, reg_dat_we}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_outputs", {28'h0, reg_dat_we, s_axi_bvalid, s_axi_awready, s_axi_wready}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; reg_dat_wait = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_tx", tx_bytes, 32'd0);
    check("final_queues_empty", bq.size() + rq.size() + sq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
